// File: rtl/fht_pkg.sv
// Shared constants and saturation-limit helpers for the FHT butterfly pipeline.
package fht_pkg;

    localparam int FHT_LATENCY       = 3;
    localparam int FHT_W_BIT_DEFAULT = 12;

    function automatic longint fht_unity(input int w_bit);
        return longint'(1) <<< (w_bit - 2);
    endfunction

    function automatic longint fht_sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint fht_sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    localparam longint FHT_UNITY_DEFAULT = fht_unity(FHT_W_BIT_DEFAULT);

endpackage

// File: rtl/fht_round_sat.sv
// Arithmetic right shift by SHIFT with round-half-away-from-zero (when i_en),
// followed by saturation to OUT_W signed bits.
module fht_round_sat
    import fht_pkg::*;
#(
    parameter int IN_W  = 30,
    parameter int OUT_W = 18,
    parameter int SHIFT = 10
) (
    input  logic                    i_en,
    input  logic signed [IN_W-1:0]  i_data,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_sat
);

    localparam int                     EXT_W = IN_W + 1;
    localparam longint                 MAX_L = fht_sat_max(OUT_W);
    localparam longint                 MIN_L = fht_sat_min(OUT_W);
    localparam logic signed [OUT_W-1:0] MAX_O = OUT_W'(MAX_L);
    localparam logic signed [OUT_W-1:0] MIN_O = OUT_W'(MIN_L);

    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_bias;
    logic signed [EXT_W-1:0] w_shifted;
    logic signed [63:0]      w_wide;

    assign w_ext = EXT_W'(i_data);

    // Negative values use a bias one smaller so the floor shift rounds away from zero.
    generate
        if (SHIFT > 0) begin : g_bias
            assign w_bias = i_data[IN_W-1] ? EXT_W'((longint'(1) <<< (SHIFT - 1)) - 1)
                                           : EXT_W'(longint'(1) <<< (SHIFT - 1));
        end else begin : g_nobias
            assign w_bias = '0;
        end
    endgenerate

    always_comb begin
        w_shifted = w_ext;
        if (i_en) begin
            w_shifted = (w_ext + w_bias) >>> SHIFT;
        end
    end

    assign w_wide = 64'(w_shifted);

    always_comb begin
        o_data = w_shifted[OUT_W-1:0];
        o_sat  = 1'b0;
        if (w_wide > MAX_L) begin
            o_data = MAX_O;
            o_sat  = 1'b1;
        end else if (w_wide < MIN_L) begin
            o_data = MIN_O;
            o_sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fht_but_pipe.sv
// Three-stage FHT butterfly: twiddle product, rounded M, then scaled or
// saturated sum/difference with a sticky overflow flag and event counter.
module fht_but_pipe
    import fht_pkg::*;
#(
    parameter int D_BIT   = 17,
    parameter int W_BIT   = 12,
    parameter int CNT_BIT = 8
) (
    input  logic                      iCLK,
    input  logic                      iRESET,
    input  logic                      iVALID,
    input  logic                      iBYPASS,
    input  logic                      iSCALE,
    input  logic signed [D_BIT-1:0]   iX_0,
    input  logic signed [D_BIT-1:0]   iX_1,
    input  logic signed [D_BIT-1:0]   iX_2,
    input  logic signed [W_BIT-1:0]   iSIN,
    input  logic signed [W_BIT-1:0]   iCOS,
    input  logic                      iCLR_OVF,
    output logic                      oVALID,
    output logic signed [D_BIT-1:0]   oY_0,
    output logic signed [D_BIT-1:0]   oY_1,
    output logic                      oOVF,
    output logic [CNT_BIT-1:0]        oOVF_CNT
);

    localparam int P_BIT = D_BIT + W_BIT + 1;
    localparam int M_BIT = D_BIT + 1;
    localparam int S_BIT = D_BIT + 2;
    localparam logic signed [P_BIT-1:0] UNITY   = P_BIT'(fht_unity(W_BIT));
    localparam logic [CNT_BIT-1:0]      CNT_MAX = '1;

    logic signed [P_BIT-1:0] w_p;
    logic signed [M_BIT-1:0] w_m;
    logic                    w_m_sat;
    logic signed [S_BIT-1:0] w_s;
    logic signed [S_BIT-1:0] w_d;
    logic signed [D_BIT-1:0] w_y0;
    logic signed [D_BIT-1:0] w_y1;
    logic                    w_y0_sat;
    logic                    w_y1_sat;
    logic                    w_res_sat;

    logic                    r_v1;
    logic                    r_scale1;
    logic signed [P_BIT-1:0] r_p1;
    logic signed [D_BIT-1:0] r_x0_1;

    logic                    r_v2;
    logic                    r_scale2;
    logic                    r_msat2;
    logic signed [M_BIT-1:0] r_m2;
    logic signed [D_BIT-1:0] r_x0_2;

    // Bypass scales X1 by unity so the product rounder returns X1 exactly.
    always_comb begin
        w_p = P_BIT'(iX_1) * UNITY;
        if (!iBYPASS) begin
            w_p = P_BIT'(iX_1) * P_BIT'(iCOS) + P_BIT'(iX_2) * P_BIT'(iSIN);
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_v1     <= 1'b0;
            r_scale1 <= 1'b0;
            r_p1     <= '0;
            r_x0_1   <= '0;
        end else begin
            r_v1     <= iVALID;
            r_scale1 <= iSCALE;
            r_p1     <= w_p;
            r_x0_1   <= iX_0;
        end
    end

    fht_round_sat #(.IN_W(P_BIT), .OUT_W(M_BIT), .SHIFT(W_BIT - 2)) u_round_prod (
        .i_en   (1'b1),
        .i_data (r_p1),
        .o_data (w_m),
        .o_sat  (w_m_sat)
    );

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_v2     <= 1'b0;
            r_scale2 <= 1'b0;
            r_msat2  <= 1'b0;
            r_m2     <= '0;
            r_x0_2   <= '0;
        end else begin
            r_v2     <= r_v1;
            r_scale2 <= r_scale1;
            r_msat2  <= w_m_sat;
            r_m2     <= w_m;
            r_x0_2   <= r_x0_1;
        end
    end

    assign w_s = S_BIT'(r_x0_2) + S_BIT'(r_m2);
    assign w_d = S_BIT'(r_x0_2) - S_BIT'(r_m2);

    fht_round_sat #(.IN_W(S_BIT), .OUT_W(D_BIT), .SHIFT(1)) u_round_sum (
        .i_en   (r_scale2),
        .i_data (w_s),
        .o_data (w_y0),
        .o_sat  (w_y0_sat)
    );

    fht_round_sat #(.IN_W(S_BIT), .OUT_W(D_BIT), .SHIFT(1)) u_round_diff (
        .i_en   (r_scale2),
        .i_data (w_d),
        .o_data (w_y1),
        .o_sat  (w_y1_sat)
    );

    // An out-of-range twiddle product is reported as a saturated result too.
    assign w_res_sat = r_msat2 | w_y0_sat | w_y1_sat;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            oVALID <= 1'b0;
            oY_0   <= '0;
            oY_1   <= '0;
        end else begin
            oVALID <= r_v2;
            if (r_v2) begin
                oY_0 <= w_y0;
                oY_1 <= w_y1;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            oOVF     <= 1'b0;
            oOVF_CNT <= '0;
        end else if (iCLR_OVF) begin
            oOVF     <= 1'b0;
            oOVF_CNT <= '0;
        end else if (r_v2 && w_res_sat) begin
            oOVF <= 1'b1;
            if (oOVF_CNT != CNT_MAX) begin
                oOVF_CNT <= oOVF_CNT + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fht_but_pipe.sv
// Directed self-checking bench for fht_but_pipe: hand-computed vectors, a
// streaming run against a small reference model, reset and overflow-counter cases.
module tb_fht_but_pipe;

    localparam int D_BIT   = 17;
    localparam int W_BIT   = 12;
    localparam int CNT_BIT = 8;

    logic                    iCLK = 1'b0;
    logic                    iRESET;
    logic                    iVALID;
    logic                    iBYPASS;
    logic                    iSCALE;
    logic signed [D_BIT-1:0] iX_0, iX_1, iX_2;
    logic signed [W_BIT-1:0] iSIN, iCOS;
    logic                    iCLR_OVF;
    logic                    oVALID;
    logic signed [D_BIT-1:0] oY_0, oY_1;
    logic                    oOVF;
    logic [CNT_BIT-1:0]      oOVF_CNT;

    int testsRun    = 0;
    int testsFailed = 0;

    fht_but_pipe #(.D_BIT(D_BIT), .W_BIT(W_BIT), .CNT_BIT(CNT_BIT)) dut (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .iVALID   (iVALID),
        .iBYPASS  (iBYPASS),
        .iSCALE   (iSCALE),
        .iX_0     (iX_0),
        .iX_1     (iX_1),
        .iX_2     (iX_2),
        .iSIN     (iSIN),
        .iCOS     (iCOS),
        .iCLR_OVF (iCLR_OVF),
        .oVALID   (oVALID),
        .oY_0     (oY_0),
        .oY_1     (oY_1),
        .oOVF     (oOVF),
        .oOVF_CNT (oOVF_CNT)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        testsRun++;
        if (observed != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint roundDiv(input longint x, input longint d);
        if (x >= 0) return (x + d / 2) / d;
        return -((-x + d / 2) / d);
    endfunction

    function automatic longint clampTo(input longint x, input int w);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic modelButterfly(input longint x0, x1, x2, c, s, input bit byp, sc,
                                  output longint y0, y1, output bit sat);
        longint p, m, mc, sv, dv, y0c, y1c;
        p  = byp ? x1 * 1024 : x1 * c + x2 * s;
        m  = roundDiv(p, 1024);
        mc = clampTo(m, D_BIT + 1);
        sv = x0 + mc;
        dv = x0 - mc;
        if (sc) begin
            sv = roundDiv(sv, 2);
            dv = roundDiv(dv, 2);
        end
        y0c = clampTo(sv, D_BIT);
        y1c = clampTo(dv, D_BIT);
        y0  = y0c;
        y1  = y1c;
        sat = (mc != m) || (y0c != sv) || (y1c != dv);
    endtask

    task automatic driveSample(input longint x0, x1, x2, c, s, input bit byp, sc);
        iVALID  = 1'b1;
        iX_0    = D_BIT'(x0);
        iX_1    = D_BIT'(x1);
        iX_2    = D_BIT'(x2);
        iCOS    = W_BIT'(c);
        iSIN    = W_BIT'(s);
        iBYPASS = byp;
        iSCALE  = sc;
    endtask

    // One isolated sample; returns #1 after the third edge, when the result is visible.
    task automatic applyStimulus(input longint x0, x1, x2, c, s, input bit byp, sc);
        @(posedge iCLK); #1;
        driveSample(x0, x1, x2, c, s, byp, sc);
        @(posedge iCLK); #1;
        iVALID = 1'b0;
        @(posedge iCLK); #1;
        checkOutput("latency_early", oVALID, 0);
        @(posedge iCLK); #1;
    endtask

    task automatic pulseClear();
        @(posedge iCLK); #1;
        iCLR_OVF = 1'b1;
        @(posedge iCLK); #1;
        iCLR_OVF = 1'b0;
    endtask

    longint ey0 [100];
    longint ey1 [100];
    longint my0, my1, rx0, rx1, rx2, rc, rs;
    bit     msat;
    int     modelCnt;
    bit     modelOvf;
    int     got;

    initial begin
        iRESET   = 1'b1;
        iVALID   = 1'b0;
        iBYPASS  = 1'b0;
        iSCALE   = 1'b0;
        iX_0     = '0;
        iX_1     = '0;
        iX_2     = '0;
        iSIN     = '0;
        iCOS     = '0;
        iCLR_OVF = 1'b0;
        #1;
        checkOutput("reset_valid", oVALID, 0);
        checkOutput("reset_y0", oY_0, 0);
        checkOutput("reset_y1", oY_1, 0);
        checkOutput("reset_ovf", oOVF, 0);
        checkOutput("reset_cnt", oOVF_CNT, 0);
        repeat (2) @(posedge iCLK);
        #1 iRESET = 1'b0;

        applyStimulus(100, 50, 0, 1024, 0, 0, 1);
        checkOutput("basic_valid", oVALID, 1);
        checkOutput("basic_y0", oY_0, 75);
        checkOutput("basic_y1", oY_1, 25);
        checkOutput("basic_ovf", oOVF, 0);

        applyStimulus(3, 0, 0, 1024, 0, 0, 1);
        checkOutput("round_pos_y0", oY_0, 2);
        checkOutput("round_pos_y1", oY_1, 2);
        applyStimulus(-3, 0, 0, 1024, 0, 0, 1);
        checkOutput("round_neg_y0", oY_0, -2);
        checkOutput("round_neg_y1", oY_1, -2);

        applyStimulus(10, 1000, -500, 724, 724, 0, 0);
        checkOutput("rot_pos_y0", oY_0, 364);
        checkOutput("rot_pos_y1", oY_1, -344);
        applyStimulus(10, -1000, 500, 724, 724, 0, 0);
        checkOutput("rot_neg_y0", oY_0, -344);
        checkOutput("rot_neg_y1", oY_1, 364);

        applyStimulus(0, 1, 0, 512, 0, 0, 0);
        checkOutput("mhalf_pos_y0", oY_0, 1);
        checkOutput("mhalf_pos_y1", oY_1, -1);
        applyStimulus(0, -1, 0, 512, 0, 0, 0);
        checkOutput("mhalf_neg_y0", oY_0, -1);
        checkOutput("mhalf_neg_y1", oY_1, 1);

        applyStimulus(65535, 65535, 0, 0, 0, 1, 0);
        checkOutput("sat_hi_y0", oY_0, 65535);
        checkOutput("sat_hi_y1", oY_1, 0);
        checkOutput("sat_hi_ovf", oOVF, 1);
        checkOutput("sat_hi_cnt", oOVF_CNT, 1);
        applyStimulus(-65536, 1, 0, 0, 0, 1, 0);
        checkOutput("sat_lo_y0", oY_0, -65535);
        checkOutput("sat_lo_y1", oY_1, -65536);
        checkOutput("sat_lo_cnt", oOVF_CNT, 2);

        pulseClear();
        checkOutput("clear_ovf", oOVF, 0);
        checkOutput("clear_cnt", oOVF_CNT, 0);
        repeat (2) @(posedge iCLK);
        #1;
        checkOutput("hold_valid", oVALID, 0);
        checkOutput("hold_y0", oY_0, -65535);
        checkOutput("hold_y1", oY_1, -65536);

        modelCnt = 0;
        modelOvf = 1'b0;
        got      = 0;
        for (int c = 0; c < 103; c++) begin
            @(posedge iCLK); #1;
            if (c >= 3) begin
                if (oVALID) got++;
                checkOutput("stream_valid", oVALID, 1);
                checkOutput("stream_y0", oY_0, ey0[c-3]);
                checkOutput("stream_y1", oY_1, ey1[c-3]);
            end
            if (c < 100) begin
                rx0 = longint'($urandom_range(131071, 0)) - 65536;
                rx1 = longint'($urandom_range(131071, 0)) - 65536;
                rx2 = longint'($urandom_range(131071, 0)) - 65536;
                rc  = longint'($urandom_range(2048, 0)) - 1024;
                rs  = longint'($urandom_range(2048, 0)) - 1024;
                driveSample(rx0, rx1, rx2, rc, rs, bit'(c % 2), bit'(1 - c % 2));
                modelButterfly(rx0, rx1, rx2, rc, rs, bit'(c % 2), bit'(1 - c % 2), my0, my1, msat);
                ey0[c] = my0;
                ey1[c] = my1;
                if (msat) begin
                    modelOvf = 1'b1;
                    if (modelCnt < 255) modelCnt++;
                end
            end else begin
                iVALID = 1'b0;
            end
        end
        @(posedge iCLK); #1;
        checkOutput("stream_end_valid", oVALID, 0);
        checkOutput("stream_count", got, 100);
        checkOutput("stream_ovf", oOVF, modelOvf);
        checkOutput("stream_cnt", oOVF_CNT, modelCnt);

        @(posedge iCLK); #1;
        driveSample(200, 100, 0, 1024, 0, 0, 0);
        @(posedge iCLK); #1;
        driveSample(7, 7, 0, 1024, 0, 0, 0);
        @(posedge iCLK); #1;
        driveSample(9, 9, 0, 1024, 0, 0, 0);
        @(posedge iCLK); #1;
        iVALID = 1'b0;
        checkOutput("pre_reset_valid", oVALID, 1);
        checkOutput("pre_reset_y0", oY_0, 300);
        #1 iRESET = 1'b1;
        #1;
        checkOutput("async_reset_valid", oVALID, 0);
        checkOutput("async_reset_y0", oY_0, 0);
        checkOutput("async_reset_y1", oY_1, 0);
        checkOutput("async_reset_ovf", oOVF, 0);
        checkOutput("async_reset_cnt", oOVF_CNT, 0);
        repeat (2) @(posedge iCLK);
        #1 iRESET = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge iCLK); #1;
            checkOutput("no_stale_valid", oVALID, 0);
        end
        applyStimulus(100, 50, 0, 1024, 0, 0, 1);
        checkOutput("post_reset_y0", oY_0, 75);
        checkOutput("post_reset_y1", oY_1, 25);

        for (int c = 0; c < 300; c++) begin
            @(posedge iCLK); #1;
            driveSample(65535, 65535, 0, 0, 0, 1, 0);
        end
        @(posedge iCLK); #1;
        iVALID = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        checkOutput("cnt_saturate", oOVF_CNT, 255);
        checkOutput("cnt_saturate_ovf", oOVF, 1);

        @(posedge iCLK); #1;
        driveSample(65535, 65535, 0, 0, 0, 1, 0);
        @(posedge iCLK); #1;
        iVALID = 1'b0;
        @(posedge iCLK); #1;
        iCLR_OVF = 1'b1;
        @(posedge iCLK); #1;
        iCLR_OVF = 1'b0;
        checkOutput("clr_win_valid", oVALID, 1);
        checkOutput("clr_win_y0", oY_0, 65535);
        checkOutput("clr_win_ovf", oOVF, 0);
        checkOutput("clr_win_cnt", oOVF_CNT, 0);
        @(posedge iCLK); #1;
        checkOutput("clr_after_cnt", oOVF_CNT, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
